// File: rtl/dmem_resp_ctrl.sv
// Data-memory responder for the MEM stage: valid/ready request, fixed-latency response pulse.
// Optional build macro DMEM_CLEAR_ON_RST_EN zero-fills the array after every reset.
module dmem_resp_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store_type,
  input  logic [2:0]  req_load_type,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2
`ifdef DMEM_CLEAR_ON_RST_EN
    , ST_CLEAR = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_st;
  logic [2:0]  r_lt;
  logic [31:0] r_rd_word;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem [DEPTH_WORDS];
`ifdef DMEM_CLEAR_ON_RST_EN
  logic [AW-1:0] r_clr_idx;
`endif

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_oor;
  logic          w_illegal;
  logic          w_size_half;
  logic          w_size_word;
  logic          w_misalign;
  logic          w_err;
  logic          w_commit;
  logic [3:0]    w_lane_sel;
  logic [31:0]   w_lane_data;
  logic [3:0]    w_we;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
`ifdef DMEM_CLEAR_ON_RST_EN
  assign busy = (r_state != ST_IDLE) && !rst;
`else
  assign busy = (r_state != ST_IDLE);
`endif

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Error decode works on the latched request, so inputs may change after accept
  assign w_idx       = r_addr[AW+1:2];
  assign w_oor       = |r_addr[31:AW+2];
  assign w_illegal   = r_write ? (r_st == 2'b11)
                               : ((r_lt[1:0] == 2'b11) || (r_lt[2] && r_lt[1]));
  assign w_size_half = r_write ? (r_st == 2'b01) : (r_lt[1:0] == 2'b01);
  assign w_size_word = r_write ? (r_st == 2'b10) : (r_lt[1:0] == 2'b10);
  assign w_misalign  = (w_size_half && r_addr[0]) || (w_size_word && (r_addr[1:0] != 2'b00));
  assign w_err       = w_oor || w_illegal || w_misalign;
  assign w_commit    = (r_state == ST_RESP) && r_write && !w_err && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_sel[gi] = w_size_word ? 1'b1 :
                              w_size_half ? (r_addr[1] == 1'(gi / 2)) :
                                            (r_addr[1:0] == 2'(gi));
      assign w_lane_data[8*gi +: 8] = w_size_word ? r_wdata[8*gi +: 8] :
                                      w_size_half ? r_wdata[8*(gi % 2) +: 8] :
                                                    r_wdata[7:0];
    end
  endgenerate

  always_comb begin
    w_we      = 4'h0;
    w_wr_idx  = w_idx;
    w_wr_data = w_lane_data;
    if (w_commit) w_we = w_lane_sel;
`ifdef DMEM_CLEAR_ON_RST_EN
    if ((r_state == ST_CLEAR) && !rst) begin
      w_we      = 4'hF;
      w_wr_idx  = r_clr_idx;
      w_wr_data = 32'h0;
    end
`endif
  end

  // While idle the read port follows the incoming address so LATENCY=1 still sees the word in RESP
  assign w_rd_idx = (r_state == ST_IDLE) ? req_addr[AW+1:2] : w_idx;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_we[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
    end
    r_rd_word <= r_mem[w_rd_idx];
  end

  assign w_byte = r_rd_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_load = 32'h0;
    case (r_lt)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = r_rd_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_CLEAR_ON_RST_EN
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
`else
      r_state   <= ST_IDLE;
`endif
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_st         <= 2'b00;
      r_lt         <= 3'b000;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_st    <= req_store_type;
            r_lt    <= req_load_type;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= w_err;
          r_resp_rdata <= (w_err || r_write) ? 32'h0 : w_load;
          r_state      <= ST_IDLE;
        end
`ifdef DMEM_CLEAR_ON_RST_EN
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == AW'(DEPTH_WORDS - 1)) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_resp_ctrl.md
Name: dmem_resp_ctrl

Overview:
Data-memory responder that services the load/store requests issued by the MEM pipeline stage. It uses a valid/ready request channel with a fixed-latency response pulse. It implements RISC-V byte/half/word store lane merging, load sign/zero extension, and alignment/range error checking over an internal word-addressed array. It is the slave end of the MEM-stage memory interface and replaces the single-cycle array behind that stage.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
LATENCY, 2, cycles from request accept edge to resp_valid (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data; bytes taken from low lanes.
req_store_type  input  2  00 SB, 01 SH, 10 SW, 11 illegal.
req_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others illegal.
resp_valid  output  1  one-cycle response pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  valid with resp_valid: misaligned, out of range, or illegal type.
busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP (plus CLEAR when the optional feature is compiled in).
- req_ready = (state == IDLE) && !rst. Accept = req_valid && req_ready.
- On accept: latch write, addr, wdata, and type fields; load the down-counter with LATENCY-1.
- Next state: RESP if LATENCY == 1, else WAIT.
- WAIT: decrement each cycle; go to RESP when the counter reaches 0.
- RESP: resp_valid = 1 for exactly one cycle; next state IDLE. No backpressure on responses.
- Timing: accept at edge N gives resp_valid high in the cycle after edge N+LATENCY. Throughput is one request per LATENCY+1 cycles.
- Request fields are ignored when not accepted. Inputs may change freely after accept.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Out of range if any addr bit above that index field is nonzero.
- Misalignment rules:
  - SH/LH/LHU with addr[0] = 1.
  - SW/LW with addr[1:0] != 0.
- Any error: resp_err = 1, resp_rdata = 0, array unchanged.
- Store commit:
  - Commits at the RESP edge, i.e. the same edge that raises resp_valid.
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes. Other lanes are preserved.
- Load read:
  - Reads array contents at the RESP edge, so a prior store is always visible.
  - LB/LH sign-extend the selected byte/half; LBU/LHU zero-extend; LW passes the word.
- resp_rdata and resp_err are registered and hold their value only while resp_valid = 1; they are 0 otherwise.
- Reset values: resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, state IDLE, counter 0. req_ready = 1 the first cycle after rst falls.
- Reset mid-operation (WAIT or RESP): the transaction is aborted, no store commits, and no resp_valid is produced. Array contents are retained, except as described under the optional feature.
- rst has priority over accept in the same cycle.

Optional Feature:
DMEM_CLEAR_ON_RST_EN
- Defined: after rst falls the FSM enters CLEAR and writes zero to word 0..DEPTH_WORDS-1, one word per cycle.
  - req_ready = 0 and busy = 1 for exactly DEPTH_WORDS cycles, then IDLE.
  - rst during CLEAR restarts the clear from word 0.
- Undefined: no CLEAR state; IDLE immediately after reset; array contents after power-up are unspecified and retained across reset.

Test Plan:
1. Reset, then SW addr 0x10 data 0xDEADBEEF; then LW 0x10 -> resp_valid 2 cycles after each accept; LW returns 0xDEADBEEF, resp_err = 0.
2. After test 1: SB addr 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
3. SH addr 0x22 data 0x1234F00D, then LHU 0x22 -> 0x0000F00D; LH 0x22 -> 0xFFFFF00D; LW 0x20 -> upper half 0xF00D, lower half unchanged.
4. Error cases:
   - LW 0x11 -> resp_err = 1, rdata 0.
   - SH 0x21 -> resp_err = 1, and LW 0x20 is unchanged afterwards.
   - LW 0x1000 with DEPTH_WORDS = 1024 -> resp_err = 1.
   - load_type 011 -> resp_err = 1.
5. Assert rst in the WAIT cycle of SW 0x30 data 0x55 -> no resp_valid; later LW 0x30 returns the pre-store value. Also check that req_valid held high during busy is not accepted until state returns to IDLE.
6. With DMEM_CLEAR_ON_RST_EN and DEPTH_WORDS = 16: store 0xA5A5A5A5 to 0x04, pulse rst -> req_ready low for exactly 16 cycles; then LW 0x04 -> 0x00000000.
